// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data memory responder.
package dmem_pkg;

   localparam int unsigned DEPTH_DEFAULT   = 256;
   localparam int unsigned LATENCY_DEFAULT = 2;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
interface data_mem_responder_if;

   logic        memRead;
   logic        memWrite;
   logic [31:0] addr;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ack;
   logic        stall;
   logic        err;

   modport master (
      output memRead, memWrite, addr, writeData,
      input  readData, ack, stall, err
   );

   modport slave (
      input  memRead, memWrite, addr, writeData,
      output readData, ack, stall, err
   );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 data storage: synchronous write, combinational read, never reset.
module dmem_array #(
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the MEM stage.
// Defining DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEFAULT,
   parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_t            state, next_state;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              accept;
   logic              wr_q, rd_q, mis_q;
   logic [AW-1:0]     word_q;
   logic [31:0]       wdata_q, rdata_q, mem_rdata;
   logic              req, req_rd, req_mis;
   logic [AW-1:0]     req_word, raddr;
   logic              load_rd, mem_we, ack;
   logic              unused_addr_bits;

   assign req      = bus.memRead | bus.memWrite;
   assign req_rd   = bus.memRead & ~bus.memWrite;
   assign req_word = bus.addr[AW+1:2];
   assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_mis = |bus.addr[1:0];
`else
   assign req_mis = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (LATENCY > 1) begin
                  next_state = BUSY;
                  cnt_next   = CNT_W'(LATENCY - 1);
               end else begin
                  next_state = RESP;
               end
            end
         end
         BUSY: begin
            cnt_next = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         mis_q   <= 1'b0;
         word_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= bus.memWrite;
         rd_q    <= req_rd;
         mis_q   <= req_mis;
         word_q  <= req_word;
         wdata_q <= bus.writeData;
      end
   end

   // With LATENCY==1 RESP is entered straight from IDLE, so the load must use
   // the live request rather than the copy latched on that same edge.
   assign raddr   = (state == IDLE) ? req_word : word_q;
   assign load_rd = (next_state == RESP) && (state != RESP) &&
                    ((state == IDLE) ? (req_rd & ~req_mis) : (rd_q & ~mis_q));
   assign mem_we  = (state == RESP) && wr_q && !mis_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (load_rd) begin
         rdata_q <= mem_rdata;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (word_q),
      .wdata (wdata_q),
      .raddr (raddr),
      .rdata (mem_rdata)
   );

   assign ack          = (state == RESP);
   assign bus.ack      = ack;
   assign bus.err      = ack & mis_q;
   assign bus.stall    = req & ~ack;
   assign bus.readData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances.
module tb_data_mem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   data_mem_responder_if if2 ();
   data_mem_responder_if if1 ();

   data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2)
   );

   data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   always #5 clk = ~clk;

   // Present one request on if2 at the current negedge and hold it until ack.
   // Returns the ack cycle (0 = presentation cycle), stall-high count and err.
   task automatic acc(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output int stalls,
                      output logic e);
      lat = -1;
      stalls = 0;
      e = 1'b0;
      if2.memRead = rd;
      if2.memWrite = wr;
      if2.addr = a;
      if2.writeData = wd;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (if2.stall) stalls++;
         if (if2.ack) begin
            lat = c;
            e = if2.err;
            break;
         end
         @(negedge clk);
         #1;
      end
      if2.memRead = 1'b0;
      if2.memWrite = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      if2.memRead = 1'b0; if2.memWrite = 1'b0; if2.addr = '0; if2.writeData = '0;
      if1.memRead = 1'b0; if1.memWrite = 1'b0; if1.addr = '0; if1.writeData = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (if2.readData !== 32'h0) begin failures++; $display("FAIL rst_rdata2: got %h expected %h", if2.readData, 32'h0); end
      checks++; if (if2.ack !== 1'b0) begin failures++; $display("FAIL rst_ack2: got %b expected 0", if2.ack); end
      checks++; if (if2.err !== 1'b0) begin failures++; $display("FAIL rst_err2: got %b expected 0", if2.err); end
      checks++; if (if2.stall !== 1'b0) begin failures++; $display("FAIL rst_stall2: got %b expected 0", if2.stall); end
      checks++; if (if1.readData !== 32'h0) begin failures++; $display("FAIL rst_rdata1: got %h expected %h", if1.readData, 32'h0); end
      checks++; if (if1.ack !== 1'b0) begin failures++; $display("FAIL rst_ack1: got %b expected 0", if1.ack); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int lat, st;
      logic e;
      acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, st, e);
      checks++; if (lat !== 2) begin failures++; $display("FAIL wr_lat: got %0d expected 2", lat); end
      checks++; if (st !== 2) begin failures++; $display("FAIL wr_stall: got %0d expected 2", st); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err: got %b expected 0", e); end
      acc(1'b1, 1'b0, 32'h10, 32'h0, lat, st, e);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rd_lat: got %0d expected 2", lat); end
      checks++; if (st !== 2) begin failures++; $display("FAIL rd_stall: got %0d expected 2", st); end
      checks++; if (if2.readData !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data: got %h expected %h", if2.readData, 32'hDEADBEEF); end
   endtask

   task automatic test_wrap();
      int lat, st;
      logic e;
      acc(1'b0, 1'b1, 32'h400, 32'h55, lat, st, e);
      acc(1'b1, 1'b0, 32'h000, 32'h0, lat, st, e);
      checks++; if (if2.readData !== 32'h55) begin failures++; $display("FAIL wrap_data: got %h expected %h", if2.readData, 32'h55); end
   endtask

   task automatic test_both_high();
      int lat, st;
      logic e;
      acc(1'b1, 1'b0, 32'h10, 32'h0, lat, st, e);
      acc(1'b1, 1'b1, 32'h8, 32'h1234, lat, st, e);
      checks++; if (lat !== 2) begin failures++; $display("FAIL both_lat: got %0d expected 2", lat); end
      checks++; if (if2.readData !== 32'hDEADBEEF) begin failures++; $display("FAIL both_rdata_held: got %h expected %h", if2.readData, 32'hDEADBEEF); end
      acc(1'b1, 1'b0, 32'h8, 32'h0, lat, st, e);
      checks++; if (if2.readData !== 32'h1234) begin failures++; $display("FAIL both_mem2: got %h expected %h", if2.readData, 32'h1234); end
   endtask

   task automatic test_align();
      int lat, st;
      logic e;
      logic [31:0] exp_word;
      exp_word = ALIGN_EN ? 32'h11111111 : 32'h22222222;
      acc(1'b0, 1'b1, 32'h10, 32'h11111111, lat, st, e);
      acc(1'b0, 1'b1, 32'h13, 32'h22222222, lat, st, e);
      checks++; if (lat !== 2) begin failures++; $display("FAIL align_lat: got %0d expected 2", lat); end
      checks++; if (e !== ALIGN_EN) begin failures++; $display("FAIL align_err: got %b expected %b", e, ALIGN_EN); end
      acc(1'b1, 1'b0, 32'h10, 32'h0, lat, st, e);
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL align_rd_err: got %b expected 0", e); end
      checks++; if (if2.readData !== exp_word) begin failures++; $display("FAIL align_word: got %h expected %h", if2.readData, exp_word); end
   endtask

   task automatic test_reset_abort();
      int lat, st;
      logic e;
      int acks;
      acks = 0;
      acc(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, lat, st, e);
      acc(1'b1, 1'b0, 32'h20, 32'h0, lat, st, e);
      checks++; if (if2.readData !== 32'hA5A5A5A5) begin failures++; $display("FAIL abort_prior: got %h expected %h", if2.readData, 32'hA5A5A5A5); end
      if2.memWrite = 1'b1;
      if2.addr = 32'h20;
      if2.writeData = 32'h0000FFFF;
      @(negedge clk);
      #1;
      checks++; if (if2.stall !== 1'b1) begin failures++; $display("FAIL abort_busy_stall: got %b expected 1", if2.stall); end
      checks++; if (if2.ack !== 1'b0) begin failures++; $display("FAIL abort_busy_ack: got %b expected 0", if2.ack); end
      rst = 1'b1;
      if2.memWrite = 1'b0;
      #1;
      checks++; if (if2.readData !== 32'h0) begin failures++; $display("FAIL abort_async_rdata: got %h expected %h", if2.readData, 32'h0); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         if (if2.ack) acks++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         if (if2.ack) acks++;
      end
      checks++; if (acks !== 0) begin failures++; $display("FAIL abort_ack_count: got %0d expected 0", acks); end
      @(negedge clk);
      acc(1'b1, 1'b0, 32'h20, 32'h0, lat, st, e);
      checks++; if (lat !== 2) begin failures++; $display("FAIL abort_rd_lat: got %0d expected 2", lat); end
      checks++; if (if2.readData !== 32'hA5A5A5A5) begin failures++; $display("FAIL abort_mem: got %h expected %h", if2.readData, 32'hA5A5A5A5); end
   endtask

   task automatic test_back_to_back();
      logic        is_rd [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] op_a  [4]  = '{32'h0, 32'h4, 32'h0, 32'h4};
      logic [31:0] op_wd [4]  = '{32'hA0A00001, 32'hB0B00002, 32'h0, 32'h0};
      logic [31:0] exp_rd[4]  = '{32'h0, 32'h0, 32'hA0A00001, 32'hB0B00002};
      int i;
      logic exp_ack;
      i = 0;
      @(negedge clk);
      if1.memRead = is_rd[0];
      if1.memWrite = ~is_rd[0];
      if1.addr = op_a[0];
      if1.writeData = op_wd[0];
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_ack = ((k % 2) == 1);
         checks++; if (if1.ack !== exp_ack) begin failures++; $display("FAIL b2b_ack_c%0d: got %b expected %b", k, if1.ack, exp_ack); end
         checks++; if (if1.stall !== ~exp_ack) begin failures++; $display("FAIL b2b_stall_c%0d: got %b expected %b", k, if1.stall, ~exp_ack); end
         if (if1.ack && i < 4) begin
            if (is_rd[i]) begin
               checks++; if (if1.readData !== exp_rd[i]) begin failures++; $display("FAIL b2b_rdata_op%0d: got %h expected %h", i, if1.readData, exp_rd[i]); end
            end
            i++;
            if (i < 4) begin
               if1.memRead = is_rd[i];
               if1.memWrite = ~is_rd[i];
               if1.addr = op_a[i];
               if1.writeData = op_wd[i];
            end else begin
               if1.memRead = 1'b0;
               if1.memWrite = 1'b0;
            end
         end
         @(negedge clk);
      end
      checks++; if (i !== 4) begin failures++; $display("FAIL b2b_ops_done: got %0d expected 4", i); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_both_high();
      test_align();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
